// File: rtl/atomic_pkg.sv
// Shared types and constants for the atomic memory-operation unit.
// Operation encodings, the sequencing state enum and reservation constants.
package atomic_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int RESV_TAG_W   = XLEN_DEFAULT - 2;
  localparam int SC_FAIL      = 1;

  typedef enum logic [3:0] {
    LR   = 4'd0,
    SC   = 4'd1,
    SWAP = 4'd2,
    ADD  = 4'd3,
    XOR  = 4'd4,
    AND  = 4'd5,
    OR   = 4'd6,
    MIN  = 4'd7,
    MAX  = 4'd8,
    MINU = 4'd9,
    MAXU = 4'd10
  } amo_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    MODIFY = 3'd2,
    WR_REQ = 3'd3,
    DONE   = 3'd4
  } amo_state_e;

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write datapath: y = op(a, b), a = memory value, b = rs2.
// SWAP (and any non-arithmetic encoding) simply passes b through.
module amo_alu
  import atomic_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = b;
    case (amo_op_e'(op))
      ADD:     y = a + b;
      XOR:     y = a ^ b;
      AND:     y = a & b;
      OR:      y = a | b;
      MIN:     y = ($signed(a) < $signed(b)) ? a : b;
      MAX:     y = ($signed(a) > $signed(b)) ? a : b;
      MINU:    y = (a < b) ? a : b;
      MAXU:    y = (a > b) ? a : b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/atomic_unit.sv
// Atomic unit in the MEM stage: sequences LR/SC and AMO read-modify-write
// transactions on the data-memory port and tracks the LR reservation.
module atomic_unit
  import atomic_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            amo_valid,
  input  logic [3:0]      amo_op,
  input  logic [XLEN-1:0] amo_addr,
  input  logic [XLEN-1:0] amo_wdata,
  input  logic            clear_reservation,
  input  logic            snoop_valid,
  input  logic [XLEN-1:0] snoop_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [XLEN-1:0] amo_result,
  output logic            amo_result_valid,
  output logic            atomic_unit_stall,
  output logic            atomic_unit_hazard,
  output logic            amo_misaligned
);

  localparam int TAG_W = XLEN - 2;

  amo_state_e      state_reg;
  logic [3:0]      op_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] old_value_reg;
  logic [XLEN-1:0] new_value_reg;
  logic [XLEN-1:0] result_reg;
  logic            misaligned_reg;
  logic            resv_valid_reg;
  logic [TAG_W-1:0] resv_addr_reg;

  logic [XLEN-1:0]  alu_y;
  logic [TAG_W-1:0] snoop_tag;
  logic [TAG_W-1:0] addr_reg_tag;
  logic             resv_kill;
  logic             sc_hit;
  logic             snoop_hits_lr;
  logic             snoop_low_unused;

  assign snoop_tag        = snoop_addr[XLEN-1:2];
  assign addr_reg_tag     = addr_reg[XLEN-1:2];
  assign snoop_low_unused = ^snoop_addr[1:0];
  assign resv_kill        = clear_reservation || (snoop_valid && snoop_tag == resv_addr_reg);
  // A clear or snoop arriving with the SC accept beats the reservation.
  assign sc_hit           = resv_valid_reg && !resv_kill && (resv_addr_reg == amo_addr[XLEN-1:2]);
  assign snoop_hits_lr    = snoop_valid && (snoop_tag == addr_reg_tag);

  amo_alu #(.XLEN(XLEN)) u_alu (
    .op (op_reg),
    .a  (old_value_reg),
    .b  (wdata_reg),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      old_value_reg  <= '0;
      new_value_reg  <= '0;
      result_reg     <= '0;
      misaligned_reg <= 1'b0;
      resv_valid_reg <= 1'b0;
      resv_addr_reg  <= '0;
    end else begin
      if (resv_kill)
        resv_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (amo_valid) begin
            op_reg         <= amo_op;
            addr_reg       <= amo_addr;
            wdata_reg      <= amo_wdata;
            misaligned_reg <= 1'b0;
            if (amo_op == SC)
              resv_valid_reg <= 1'b0;
            if (amo_addr[1:0] != 2'b00) begin
              misaligned_reg <= 1'b1;
              result_reg     <= '0;
              state_reg      <= DONE;
            end else if (amo_op == SC) begin
              result_reg <= sc_hit ? '0 : XLEN'(SC_FAIL);
              state_reg  <= sc_hit ? WR_REQ : DONE;
            end else begin
              state_reg <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (mem_ack) begin
            old_value_reg <= mem_rdata;
            result_reg    <= mem_rdata;
            if (op_reg == LR) begin
              // Later assignment overrides the generic kill above only when
              // nothing is clearing the reservation in this same cycle.
              if (!clear_reservation && !snoop_hits_lr) begin
                resv_valid_reg <= 1'b1;
                resv_addr_reg  <= addr_reg_tag;
              end
              state_reg <= DONE;
            end else begin
              state_reg <= MODIFY;
            end
          end
        end
        MODIFY: begin
          new_value_reg <= alu_y;
          state_reg     <= WR_REQ;
        end
        WR_REQ: begin
          if (mem_ack)
            state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; reset forces everything low.
  always_comb begin
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    mem_addr           = '0;
    mem_wdata          = '0;
    amo_result         = '0;
    amo_result_valid   = 1'b0;
    atomic_unit_stall  = 1'b0;
    atomic_unit_hazard = 1'b0;
    amo_misaligned     = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE:   atomic_unit_stall = amo_valid;
        RD_REQ: begin
          atomic_unit_stall = 1'b1;
          mem_req           = 1'b1;
          mem_addr          = addr_reg;
        end
        MODIFY: atomic_unit_stall = 1'b1;
        WR_REQ: begin
          atomic_unit_stall = 1'b1;
          mem_req           = 1'b1;
          mem_we            = 1'b1;
          mem_addr          = addr_reg;
          mem_wdata         = (op_reg == SC || op_reg == SWAP) ? wdata_reg : new_value_reg;
        end
        DONE: begin
          atomic_unit_hazard = 1'b1;
          amo_result_valid   = 1'b1;
          amo_result         = result_reg;
          amo_misaligned     = misaligned_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atomic_unit.sv
// Self-checking bench for atomic_unit: directed scenarios plus random traffic,
// compared against a word-level memory/reservation reference model.
module tb_atomic_unit;
  import atomic_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            amo_valid;
  logic [3:0]      amo_op;
  logic [XLEN-1:0] amo_addr, amo_wdata;
  logic            clear_reservation, snoop_valid;
  logic [XLEN-1:0] snoop_addr;
  logic            mem_req, mem_we, mem_ack;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [XLEN-1:0] amo_result;
  logic            amo_result_valid, atomic_unit_stall, atomic_unit_hazard, amo_misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atomic_unit #(.XLEN(XLEN)) dut (
    .clk                (clk),
    .reset              (reset),
    .amo_valid          (amo_valid),
    .amo_op             (amo_op),
    .amo_addr           (amo_addr),
    .amo_wdata          (amo_wdata),
    .clear_reservation  (clear_reservation),
    .snoop_valid        (snoop_valid),
    .snoop_addr         (snoop_addr),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_ack            (mem_ack),
    .amo_result         (amo_result),
    .amo_result_valid   (amo_result_valid),
    .atomic_unit_stall  (atomic_unit_stall),
    .atomic_unit_hazard (atomic_unit_hazard),
    .amo_misaligned     (amo_misaligned)
  );

  // Memory responder: acks after ack_delay extra cycles of a held request.
  logic [31:0] mem [0:255];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = '0, poke_data = '0;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem_req ? mem[mem_addr[9:2]] : '0;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_we && mem_ack) mem[mem_addr[9:2]] <= mem_wdata;
    if (poke_en) mem[poke_addr[9:2]] <= poke_data;
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  bit          ref_rv = 1'b0;
  logic [29:0] ref_tag = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input amo_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ADD:     return a + b;
      XOR:     return a ^ b;
      AND:     return a & b;
      OR:      return a | b;
      MIN:     return (int'(a) < int'(b)) ? a : b;
      MAX:     return (int'(a) > int'(b)) ? a : b;
      MINU:    return (a < b) ? a : b;
      MAXU:    return (a > b) ? a : b;
      default: return b;
    endcase
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    ref_mem[addr[9:2]] = data;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Predicts result, cycle counts and memory effect of one instruction.
  task automatic model(input amo_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit clr_acc, output logic [31:0] e_res, output int e_lat,
                       output int e_req, output int e_we, output bit e_mis);
    int d = ack_delay;
    int idx = int'(addr[9:2]);
    logic [31:0] old;
    e_req = 0; e_we = 0; e_mis = 1'b0;
    if (clr_acc) ref_rv = 1'b0;
    if (addr[1:0] != 2'b00) begin
      e_res = 0; e_lat = 2; e_mis = 1'b1;
      if (op == SC) ref_rv = 1'b0;
    end else if (op == LR) begin
      e_res = ref_mem[idx]; e_lat = 3 + d; e_req = d + 1;
      ref_rv = 1'b1; ref_tag = addr[31:2];
    end else if (op == SC) begin
      if (ref_rv && ref_tag == addr[31:2]) begin
        ref_mem[idx] = wdata;
        e_res = 0; e_lat = 3 + d; e_req = d + 1; e_we = d + 1;
      end else begin
        e_res = 1; e_lat = 2;
      end
      ref_rv = 1'b0;
    end else begin
      old = ref_mem[idx];
      ref_mem[idx] = ref_alu(op, old, wdata);
      e_res = old; e_lat = 5 + 2 * d; e_req = 2 * d + 2; e_we = d + 1;
    end
  endtask

  task automatic issue(input amo_op_e op, input logic [31:0] addr, input logic [31:0] wdata, input bit clr_acc);
    logic [31:0] e_res, res;
    int e_lat, e_req, e_we, lat, n_stall, n_req, n_we;
    bit e_mis, done;
    logic mis, haz;
    res = '0; lat = 0; n_stall = 0; n_req = 0; n_we = 0; done = 1'b0; mis = 1'b0; haz = 1'b0;
    model(op, addr, wdata, clr_acc, e_res, e_lat, e_req, e_we, e_mis);
    @(negedge clk);
    amo_valid = 1'b1; amo_op = op; amo_addr = addr; amo_wdata = wdata; clear_reservation = clr_acc;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (atomic_unit_stall) n_stall++;
      if (mem_req) n_req++;
      if (mem_we) n_we++;
      if (amo_result_valid) begin
        done = 1'b1; lat = c + 1; res = amo_result; mis = amo_misaligned; haz = atomic_unit_hazard;
      end
      @(negedge clk);
      amo_valid = 1'b0; clear_reservation = 1'b0;
      amo_wdata = $urandom; amo_addr = $urandom;
    end
    check("completed", 32'(done), 32'd1);
    check("result", res, e_res);
    check("latency", lat, e_lat);
    check("stall_cycles", n_stall, e_lat - 1);
    check("req_cycles", n_req, e_req);
    check("we_cycles", n_we, e_we);
    check("misaligned", 32'(mis), 32'(e_mis));
    check("hazard", 32'(haz), 32'd1);
    if (addr[1:0] == 2'b00) check("mem_word", mem[addr[9:2]], ref_mem[addr[9:2]]);
    $display("op=%0d addr=%08h wdata=%08h delay=%0d result=%08h lat=%0d", op, addr, wdata, ack_delay, res, lat);
  endtask

  task automatic snoop(input logic [31:0] addr);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = addr;
    if (ref_rv && ref_tag == addr[31:2]) ref_rv = 1'b0;
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  task automatic clear_resv();
    @(negedge clk);
    clear_reservation = 1'b1; ref_rv = 1'b0;
    @(negedge clk);
    clear_reservation = 1'b0;
  endtask

  initial begin
    int wr_seen;
    int rv_seen;
    reset = 1'b1; amo_valid = 1'b1; amo_op = ADD; amo_addr = 32'h100; amo_wdata = 32'h3;
    clear_reservation = 1'b0; snoop_valid = 1'b0; snoop_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(atomic_unit_stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_result_valid", 32'(amo_result_valid), 32'd0);
    check("rst_result", amo_result, 32'd0);
    amo_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_stall", 32'(atomic_unit_stall), 32'd0);
    check("idle_hazard", 32'(atomic_unit_hazard), 32'd0);

    for (int i = 0; i < 8; i++) poke(32'h100 + 32'(4 * i), $urandom);
    poke(32'h200, 32'h55);

    // AMOADD with single-cycle acks
    poke(32'h100, 32'd5);
    issue(ADD, 32'h100, 32'd3, 1'b0);
    // LR / SC hit / SC miss
    issue(LR, 32'h200, 32'h0, 1'b0);
    issue(SC, 32'h200, 32'd7, 1'b0);
    issue(SC, 32'h200, 32'd9, 1'b0);
    // Snoop to the same word kills the reservation
    issue(LR, 32'h200, 32'h0, 1'b0);
    snoop(32'h202);
    issue(SC, 32'h200, 32'd11, 1'b0);
    // Clear arriving with the SC accept wins
    issue(LR, 32'h200, 32'h0, 1'b0);
    issue(SC, 32'h200, 32'd12, 1'b1);
    // Signed vs unsigned minimum
    poke(32'h108, 32'hFFFF_FFFF);
    issue(MIN, 32'h108, 32'd1, 1'b0);
    poke(32'h108, 32'hFFFF_FFFF);
    issue(MINU, 32'h108, 32'd1, 1'b0);
    // Misaligned access
    issue(OR, 32'h103, 32'hF0, 1'b0);

    // Reset in the second WR_REQ cycle of a slow SWAP
    issue(LR, 32'h110, 32'h0, 1'b0);
    ack_delay = 2;
    @(negedge clk);
    amo_valid = 1'b1; amo_op = SWAP; amo_addr = 32'h110; amo_wdata = 32'hDEAD_BEEF;
    wr_seen = 0;
    for (int c = 0; c < 100 && wr_seen < 2; c++) begin
      #1;
      if (mem_we) wr_seen++;
      if (wr_seen < 2) begin
        @(negedge clk);
        amo_valid = 1'b0;
      end
    end
    check("swap_wr_reached", wr_seen, 32'd2);
    reset = 1'b1;
    #1;
    check("rst_drops_req_now", 32'(mem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_rv = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (amo_result_valid || mem_req || atomic_unit_stall) rv_seen++;
      @(negedge clk);
    end
    check("post_reset_quiet", rv_seen, 32'd0);
    check("swap_mem_unwritten", mem[8'h44], ref_mem[8'h44]);
    ack_delay = 0;
    issue(SC, 32'h110, 32'd1, 1'b0);

    // Random traffic
    begin
      logic [31:0] last_lr;
      bit          have_lr;
      have_lr = 1'b0; last_lr = '0;
      for (int i = 0; i < 40; i++) begin
        amo_op_e     op;
        logic [31:0] addr;
        int          r;
        ack_delay = int'($urandom_range(0, 2));
        op   = amo_op_e'($urandom_range(0, 10));
        addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
        if (have_lr && $urandom_range(0, 1) == 1) begin op = SC; addr = last_lr; end
        if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
        r = int'($urandom_range(0, 5));
        if (r == 0) snoop(32'h100 + 32'($urandom_range(0, 31)));
        else if (r == 1) clear_resv();
        issue(op, addr, $urandom, $urandom_range(0, 7) == 0);
        have_lr = (op == LR) && (addr[1:0] == 2'b00);
        last_lr = addr;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
